monitor_conflito_semaforo: RTL and testbench
============================================

Name: monitor_conflito_semaforo

Overview:
- Safety stage directly downstream of the intersection traffic-light controller.
- Registers the controller's 14 three-bit lamp codes onto the lamp drivers.
- Checks every cycle for conflicting greens and for illegal codes. If a fault persists, it latches and forces a fail-safe pattern: vehicle heads flash amber, pedestrian heads go dark.
- The fault stays latched until a clear is given while the inputs are clean.

Parameters:
- N_LIGHTS, 14, number of lamp heads; bus width is 3*N_LIGHTS.
- VEH_MASK, 14'b00000000001111, heads that flash amber in fault (bit i = head i). All other heads are dark in fault.
- CONFLICT_A, 14'b00000000000101, group A heads; no head here may be green together with any head in group B.
- CONFLICT_B, 14'b00000000001010, group B heads.
- DEBOUNCE, 4, consecutive bad cycles required before a fault latches (1..15).
- FLASH_HALF, 2, tick count per flash half-period (1..255).
- HOLD_MAX, 120, watchdog limit in ticks (WATCHDOG_EN only).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- tick  in  1  one-cycle time-base strobe (same strobe that paces the controller)
- light_in  in  3*N_LIGHTS  controller lamp codes; head i = bits [3i+2:3i]; 100 red, 010 amber, 001 green
- fault_clr  in  1  one-cycle clear request
- light_out  out  3*N_LIGHTS  lamp driver codes
- fault  out  1  high while in FAULT
- fault_code  out  2  latched cause: 0 none, 1 conflict, 2 illegal code, 3 watchdog

Behaviour:
- Reset (rst=0, asynchronous):
  - light_out = 3'b100 on every head;
  - fault = 0, fault_code = 0;
  - state NORMAL; all counters 0; flash phase OFF.
- Combinational checks on light_in:
  - conflict = (any head in CONFLICT_A is 001) AND (any head in CONFLICT_B is 001);
  - illegal = any head whose code is not in {100, 010, 001}.
  - bad = conflict OR illegal.
  - cause priority: conflict > illegal > watchdog.
- State machine (three states):
  - NORMAL:
    - light_out <= light_in (1-cycle latency).
    - If bad: go to SUSPECT with cnt = 1; light_out holds its last value, so no bad pattern ever reaches the lamps.
  - SUSPECT:
    - light_out holds.
    - If bad and cnt+1 == DEBOUNCE: go to FAULT and latch fault_code from the current cycle's cause.
    - Else if bad: cnt++.
    - If clean: go to NORMAL, cnt = 0, light_out <= light_in in that same cycle.
    - DEBOUNCE = 1 means a fault latches on the second consecutive bad cycle.
  - FAULT:
    - fault = 1.
    - Flash counter advances only on tick; every FLASH_HALF ticks the phase toggles.
    - Phase ON: VEH_MASK heads = 010. Phase OFF: VEH_MASK heads = 000. Non-VEH heads = 000 in both phases.
    - Entry phase is ON with counter 0.
    - Exit: fault_clr=1 AND current light_in clean → go to NORMAL next cycle; light_out <= light_in; fault = 0; fault_code = 0.
    - fault_clr while light_in is bad is ignored (no state change, no flag).
- fault_clr in NORMAL or SUSPECT: no effect.
- tick and a bad input in the same cycle: both processed independently.
- All counters saturate; none wraps.

Optional Feature:
- Macro: SEMAFORO_WATCHDOG_EN.
- With the macro defined:
  - a hold counter counts ticks while light_in is unchanged and is cleared on any change;
  - reaching HOLD_MAX in NORMAL or SUSPECT enters FAULT directly with fault_code = 3, bypassing DEBOUNCE;
  - if conflict or illegal is also true in that cycle, the higher-priority code wins;
  - the hold counter is cleared on exit from FAULT.
- Without the macro: no hold counter exists and fault_code 3 is never produced.

Test Plan:
1. Reset, then drive a legal sequence (F1 green, F2 red, others legal) → light_out equals light_in delayed by 1 clk; fault stays 0.
2. Heads 0 and 1 both 001 for 4 clks (DEBOUNCE=4) → light_out frozen from the first bad cycle; fault = 1 and fault_code = 1 on the 4th clk; heads 0-3 then alternate 010/000 every 2 ticks; heads 4-13 stay 000.
3. Head 5 = 3'b011 for 2 clks, then clean → no fault; light_out holds for 2 clks and then resumes passthrough.
4. In FAULT: pulse fault_clr while head 7 = 3'b111 → still FAULT. Fix the input, pulse fault_clr → next clk fault = 0, fault_code = 0, light_out = light_in.
5. Conflict and illegal in the same cycles for 4 clks → fault_code = 1. Assert rst=0 mid-FAULT → immediately all heads 100 and fault = 0.
6. With SEMAFORO_WATCHDOG_EN and HOLD_MAX=5: hold light_in constant for 5 ticks → fault = 1, fault_code = 3. Without the macro, the same stimulus gives fault = 0.

Source files
------------

// File: rtl/monitor_conflito_semaforo.sv
// Safety stage between the traffic-light controller and the lamp drivers.
// Optional hold-time watchdog is enabled by defining SEMAFORO_WATCHDOG_EN.
module monitor_conflito_semaforo #(
  parameter int unsigned          N_LIGHTS   = 14,
  parameter logic [N_LIGHTS-1:0]  VEH_MASK   = 14'b00000000001111,
  parameter logic [N_LIGHTS-1:0]  CONFLICT_A = 14'b00000000000101,
  parameter logic [N_LIGHTS-1:0]  CONFLICT_B = 14'b00000000001010,
  parameter int unsigned          DEBOUNCE   = 4,
  parameter int unsigned          FLASH_HALF = 2,
  parameter int unsigned          HOLD_MAX   = 120
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    tick,
  input  logic [3*N_LIGHTS-1:0]   light_in,
  input  logic                    fault_clr,
  output logic [3*N_LIGHTS-1:0]   light_out,
  output logic                    fault,
  output logic [1:0]              fault_code
);

  localparam int unsigned W = 3 * N_LIGHTS;

  typedef enum logic [1:0] {
    S_NORMAL  = 2'd0,
    S_SUSPECT = 2'd1,
    S_FAULT   = 2'd2
  } state_t;

  state_t       state_q;
  logic [W-1:0] light_q;
  logic         fault_q;
  logic [1:0]   code_q;
  logic [3:0]   cnt_q;
  logic [7:0]   flash_cnt_q, flash_cnt_d;
  logic         flash_on_q, flash_on_d;

  logic         grn_a, grn_b, illegal, conflict, bad;
  logic [2:0]   head;
  logic [1:0]   cause;
  logic         deb_hit;
  logic         wd_hit;

  function automatic logic [W-1:0] flash_pat(input logic on);
    logic [W-1:0] p;
    p = '0;
    for (int unsigned i = 0; i < N_LIGHTS; i++) begin
      p[3*i +: 3] = (on && VEH_MASK[i]) ? 3'b010 : 3'b000;
    end
    return p;
  endfunction

  always_comb begin
    grn_a   = 1'b0;
    grn_b   = 1'b0;
    illegal = 1'b0;
    head    = '0;
    for (int unsigned i = 0; i < N_LIGHTS; i++) begin
      head = light_in[3*i +: 3];
      if (head == 3'b001 && CONFLICT_A[i]) grn_a = 1'b1;
      if (head == 3'b001 && CONFLICT_B[i]) grn_b = 1'b1;
      if (!(head inside {3'b100, 3'b010, 3'b001})) illegal = 1'b1;
    end
  end

  assign conflict = grn_a && grn_b;
  assign bad      = conflict || illegal;
  assign cause    = conflict ? 2'd1 : (illegal ? 2'd2 : 2'd3);
  assign deb_hit  = ({1'b0, cnt_q} + 5'd1) >= 5'(DEBOUNCE);

  always_comb begin
    flash_cnt_d = flash_cnt_q;
    flash_on_d  = flash_on_q;
    if (tick) begin
      if (flash_cnt_q + 8'd1 >= 8'(FLASH_HALF)) begin
        flash_cnt_d = '0;
        flash_on_d  = ~flash_on_q;
      end else begin
        flash_cnt_d = flash_cnt_q + 8'd1;
      end
    end
  end

`ifdef SEMAFORO_WATCHDOG_EN
  localparam int unsigned HW = $clog2(HOLD_MAX + 1);

  logic [HW-1:0] hold_q, hold_d;
  logic [W-1:0]  prev_q;
  logic          clr_ok;

  assign clr_ok = (state_q == S_FAULT) && fault_clr && !bad;

  always_comb begin
    hold_d = hold_q;
    if (light_in != prev_q) begin
      hold_d = '0;
    end else if (tick && hold_q != HW'(HOLD_MAX)) begin
      hold_d = hold_q + 1'b1;
    end
  end

  assign wd_hit = (state_q != S_FAULT) && (hold_d == HW'(HOLD_MAX));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_q <= '0;
      prev_q <= {N_LIGHTS{3'b100}};
    end else begin
      prev_q <= light_in;
      hold_q <= clr_ok ? '0 : hold_d;
    end
  end
`else
  assign wd_hit = 1'b0;
`endif

  // Lamps only ever see clean controller codes or the fail-safe pattern:
  // any bad cycle freezes light_q before the pattern can be registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_NORMAL;
      light_q     <= {N_LIGHTS{3'b100}};
      fault_q     <= 1'b0;
      code_q      <= '0;
      cnt_q       <= '0;
      flash_cnt_q <= '0;
      flash_on_q  <= 1'b0;
    end else begin
      case (state_q)
        S_NORMAL, S_SUSPECT: begin
          if (wd_hit || (state_q == S_SUSPECT && bad && deb_hit)) begin
            state_q     <= S_FAULT;
            fault_q     <= 1'b1;
            code_q      <= cause;
            cnt_q       <= '0;
            flash_cnt_q <= '0;
            flash_on_q  <= 1'b1;
            light_q     <= flash_pat(1'b1);
          end else if (bad) begin
            state_q <= S_SUSPECT;
            cnt_q   <= (state_q == S_NORMAL) ? 4'd1 : cnt_q + 4'd1;
          end else begin
            state_q <= S_NORMAL;
            cnt_q   <= '0;
            light_q <= light_in;
          end
        end
        S_FAULT: begin
          if (fault_clr && !bad) begin
            state_q <= S_NORMAL;
            fault_q <= 1'b0;
            code_q  <= '0;
            light_q <= light_in;
          end else begin
            flash_cnt_q <= flash_cnt_d;
            flash_on_q  <= flash_on_d;
            light_q     <= flash_pat(flash_on_d);
          end
        end
        default: state_q <= S_NORMAL;
      endcase
    end
  end

  assign light_out  = light_q;
  assign fault      = fault_q;
  assign fault_code = code_q;

endmodule

// File: tb/tb_monitor_conflito_semaforo.sv
// Randomised bench for monitor_conflito_semaforo against a rule-level model.
module tb_monitor_conflito_semaforo;

  localparam int N    = 14;
  localparam int W    = 3 * N;
  localparam int DEB  = 4;
  localparam int FH   = 2;
  localparam int HOLD = 120;
  localparam logic [N-1:0] VEH = 14'b00000000001111;
  localparam logic [N-1:0] CA  = 14'b00000000000101;
  localparam logic [N-1:0] CB  = 14'b00000000001010;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         tick = 1'b0;
  logic         fault_clr = 1'b0;
  logic [W-1:0] light_in;
  logic [W-1:0] light_out;
  logic         fault;
  logic [1:0]   fault_code;

  monitor_conflito_semaforo #(
    .N_LIGHTS  (N),
    .DEBOUNCE  (DEB),
    .FLASH_HALF(FH),
    .HOLD_MAX  (HOLD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .tick      (tick),
    .light_in  (light_in),
    .fault_clr (fault_clr),
    .light_out (light_out),
    .fault     (fault),
    .fault_code(fault_code)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: outputs follow clean inputs, hold on bad ones, fault after a
  // run of DEB bad cycles; flash phase derived from ticks since entry.
  bit           m_fault;
  int           m_run, m_ticks, m_hold;
  logic [1:0]   m_code;
  logic [W-1:0] m_out, m_prev;

  function automatic bit f_conflict(input logic [W-1:0] v);
    bit a = 0, b = 0;
    for (int i = 0; i < N; i++) begin
      if (v[3*i +: 3] == 3'b001) begin
        if (CA[i]) a = 1;
        if (CB[i]) b = 1;
      end
    end
    return a && b;
  endfunction

  function automatic bit f_illegal(input logic [W-1:0] v);
    bit r = 0;
    for (int i = 0; i < N; i++) begin
      if (v[3*i +: 3] != 3'b100 && v[3*i +: 3] != 3'b010 && v[3*i +: 3] != 3'b001) r = 1;
    end
    return r;
  endfunction

  function automatic logic [W-1:0] f_pattern(input bit on);
    logic [W-1:0] p = '0;
    for (int i = 0; i < N; i++) p[3*i +: 3] = (on && VEH[i]) ? 3'b010 : 3'b000;
    return p;
  endfunction

  task automatic model_reset();
    m_fault = 0; m_run = 0; m_ticks = 0; m_hold = 0; m_code = 0;
    m_out   = {N{3'b100}};
    m_prev  = {N{3'b100}};
  endtask

  task automatic model_step();
    bit c, il, bad, wd;
    int need;
    c    = f_conflict(light_in);
    il   = f_illegal(light_in);
    bad  = c || il;
    wd   = 0;
    need = (DEB < 2) ? 2 : DEB;
`ifdef SEMAFORO_WATCHDOG_EN
    if (light_in != m_prev) m_hold = 0;
    else if (tick) m_hold++;
    wd = !m_fault && (m_hold >= HOLD);
`endif
    m_prev = light_in;
    if (m_fault) begin
      if (fault_clr && !bad) begin
        m_fault = 0; m_code = 0; m_out = light_in; m_run = 0; m_hold = 0;
      end else begin
        if (tick) m_ticks++;
        m_out = f_pattern(((m_ticks / FH) % 2) == 0);
      end
    end else begin
      m_run = bad ? m_run + 1 : 0;
      if (wd || m_run >= need) begin
        m_fault = 1;
        m_code  = c ? 2'd1 : (il ? 2'd2 : 2'd3);
        m_ticks = 0;
        m_run   = 0;
        m_out   = f_pattern(1);
      end else if (!bad) begin
        m_out = light_in;
      end
    end
  endtask

  task automatic step(input logic [W-1:0] v, input bit t, input bit clr);
    light_in  = v;
    tick      = t;
    fault_clr = clr;
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("light_out", 64'(light_out), 64'(m_out));
    chk("fault", 64'(fault), 64'(m_fault));
    chk("fault_code", 64'(fault_code), 64'(m_code));
  endtask

  function automatic logic [W-1:0] gen_legal();
    logic [W-1:0] v;
    int r;
    for (int i = 0; i < N; i++) begin
      r = $urandom_range(2);
      v[3*i +: 3] = (r == 0) ? 3'b100 : ((r == 1) ? 3'b010 : 3'b001);
    end
    if (f_conflict(v)) begin
      for (int i = 0; i < N; i++) if (CB[i] && v[3*i +: 3] == 3'b001) v[3*i +: 3] = 3'b100;
    end
    return v;
  endfunction

  function automatic logic [W-1:0] gen_illegal();
    logic [W-1:0] v = gen_legal();
    logic [2:0]   bc;
    int           k = $urandom_range(N - 1);
    do bc = 3'($urandom_range(7)); while (bc == 3'b100 || bc == 3'b010 || bc == 3'b001);
    v[3*k +: 3] = bc;
    return v;
  endfunction

  function automatic logic [W-1:0] gen_conflict();
    logic [W-1:0] v = gen_legal();
    v[2:0] = 3'b001;
    v[5:3] = 3'b001;
    return v;
  endfunction

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] v;
    logic [W-1:0] all_red;
    int kind, len;

    all_red  = {N{3'b100}};
    light_in = all_red;
    model_reset();
    #12;
    chk("rst_light", 64'(light_out), 64'(all_red));
    chk("rst_fault", 64'(fault), 64'd0);
    chk("rst_code", 64'(fault_code), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // legal passthrough
    for (int i = 0; i < 8; i++) step(gen_legal(), 1'($urandom_range(1)), 1'b0);

    // conflict held for DEB cycles, then flashing with ticks
    v = gen_conflict();
    for (int i = 0; i < DEB; i++) step(v, 1'b0, 1'b0);
    chk("t2_fault", 64'(fault), 64'd1);
    chk("t2_code", 64'(fault_code), 64'd1);
    chk("t2_entry_pattern", 64'(light_out), 64'(f_pattern(1)));
    for (int i = 0; i < 9; i++) step(v, 1'b1, 1'b0);

    // clear ignored while head 7 is illegal, then accepted once clean
    v = gen_legal();
    v[23:21] = 3'b111;
    step(v, 1'b1, 1'b1);
    chk("t4_still_fault", 64'(fault), 64'd1);
    v = gen_legal();
    step(v, 1'b0, 1'b1);
    chk("t4_cleared", 64'(fault), 64'd0);
    chk("t4_pass", 64'(light_out), 64'(v));

    // short illegal burst on head 5: hold, no fault, then resume
    step(gen_legal(), 1'b0, 1'b0);
    v = gen_legal();
    v[17:15] = 3'b011;
    step(v, 1'b0, 1'b0);
    step(v, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(gen_legal(), 1'b1, 1'b0);

    // conflict and illegal together: conflict wins; then reset mid-fault
    v = gen_conflict();
    v[38:36] = 3'b000;
    for (int i = 0; i < DEB; i++) step(v, 1'b1, 1'b0);
    chk("t5_code", 64'(fault_code), 64'd1);
    for (int i = 0; i < 3; i++) step(v, 1'b1, 1'b0);
    #2 rst = 1'b0;
    #1;
    model_reset();
    chk("t5_rst_light", 64'(light_out), 64'(all_red));
    chk("t5_rst_fault", 64'(fault), 64'd0);
    chk("t5_rst_code", 64'(fault_code), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // constant input over many ticks (watchdog only in the optional build)
    v = gen_legal();
    for (int i = 0; i < HOLD + 10; i++) step(v, 1'b1, 1'b0);
    step(gen_legal(), 1'b0, 1'b1);

    // random segments of repeated values
    for (int s = 0; s < 600; s++) begin
      kind = $urandom_range(9);
      len  = $urandom_range(1, 6);
      if (kind < 6)      v = gen_legal();
      else if (kind < 8) v = gen_conflict();
      else               v = gen_illegal();
      for (int i = 0; i < len; i++)
        step(v, ($urandom_range(2) == 0), ($urandom_range(5) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
